// File: rtl/ledger_pkg.sv
// Shared constants, stage/response codes and account slicing for the ledger transaction stage.
package ledger_pkg;

  localparam int NUM_ACCOUNTS = 6;
  localparam int BAL_W        = 8;
  localparam int IDX_W        = 3;
  localparam int DATA_W       = NUM_ACCOUNTS * BAL_W;

  // Stage codes seen by memory_control on the process bus.
  localparam logic [2:0] PROC_IDLE   = 3'b000;
  localparam logic [2:0] PROC_REQ    = 3'b001;
  localparam logic [2:0] PROC_CHECK  = 3'b010;
  localparam logic [2:0] PROC_UPDATE = 3'b011;
  localparam logic [2:0] PROC_WB     = 3'b100;

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_BADIDX   = 2'b01;
  localparam logic [1:0] RESP_NOFUNDS  = 2'b10;
  localparam logic [1:0] RESP_OVERFLOW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_CHECK,
    ST_UPDATE,
    ST_WB,
    ST_RESP
  } state_t;

  // Out-of-range indices read as zero so callers never part-select past the word.
  function automatic logic [BAL_W-1:0] acct_bal(input logic [DATA_W-1:0] img,
                                                input logic [IDX_W-1:0]  idx);
    logic [BAL_W-1:0] bal;
    bal = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (idx == IDX_W'(i)) bal = img[i*BAL_W +: BAL_W];
    end
    return bal;
  endfunction

endpackage

// File: rtl/ledger_if.sv
// Transfer request / response bundle between the requester (master) and ledger_datapath (slave).
interface ledger_if;
  import ledger_pkg::*;

  // A request transfers on a rising clock edge with tx_valid && tx_ready; the requester keeps
  // from/to/amount stable while tx_valid is high. resp_valid is a one-cycle strobe, no back-pressure.
  logic             tx_valid;
  logic             tx_ready;
  logic [IDX_W-1:0] tx_from;
  logic [IDX_W-1:0] tx_to;
  logic [BAL_W-1:0] tx_amount;
  logic             resp_valid;
  logic [1:0]       resp_code;

  modport master (
    output tx_valid, tx_from, tx_to, tx_amount,
    input  tx_ready, resp_valid, resp_code
  );

  modport slave (
    input  tx_valid, tx_from, tx_to, tx_amount,
    output tx_ready, resp_valid, resp_code
  );
endinterface

// File: rtl/ledger_check.sv
// Combinational transfer validation: bad index, insufficient funds, destination overflow, in that order.
module ledger_check
  import ledger_pkg::*;
(
  input  logic [DATA_W-1:0] ledger,
  input  logic [IDX_W-1:0]  from_idx,
  input  logic [IDX_W-1:0]  to_idx,
  input  logic [BAL_W-1:0]  amount,
  output logic [1:0]        code
);

  logic [BAL_W-1:0] src_bal;
  logic [BAL_W-1:0] dst_bal;
  logic [BAL_W:0]   dst_sum;
  logic             bad_idx;

  always_comb begin
    src_bal = acct_bal(ledger, from_idx);
    dst_bal = acct_bal(ledger, to_idx);
    dst_sum = {1'b0, dst_bal} + {1'b0, amount};
    bad_idx = (int'(from_idx) >= NUM_ACCOUNTS) || (int'(to_idx) >= NUM_ACCOUNTS) ||
              (from_idx == to_idx);
    code = RESP_OK;
    if (bad_idx)            code = RESP_BADIDX;
    else if (src_bal < amount) code = RESP_NOFUNDS;
    else if (dst_sum[BAL_W])   code = RESP_OVERFLOW;
  end

endmodule

// File: rtl/ledger_datapath.sv
// Transaction stage behind memory_control: load ledger word, validate and apply one transfer,
// write the image back, then return one response.
module ledger_datapath
  import ledger_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              finished_init,
  input  logic              done,
  input  logic              load_registers,
  input  logic [DATA_W-1:0] mem_q,
  output logic              load_memory,
  output logic [2:0]        process,
  output logic [DATA_W-1:0] datapath_out,
  output state_t            dbg_state,
  ledger_if.slave           bus
);

  state_t           state, state_nx;
  logic [DATA_W-1:0] ledger_q;
  logic [DATA_W-1:0] ledger_upd;
  logic [IDX_W-1:0] from_q;
  logic [IDX_W-1:0] to_q;
  logic [BAL_W-1:0] amt_q;
  logic [1:0]       code_q;
  logic [1:0]       check_code;
  logic             seen_load_q;
  logic             done_q;
  logic             tx_ready_c;
  logic             resp_valid_c;
  logic [1:0]       resp_code_c;

  ledger_check u_check (
    .ledger   (ledger_q),
    .from_idx (from_q),
    .to_idx   (to_q),
    .amount   (amt_q),
    .code     (check_code)
  );

  always_comb begin
    ledger_upd = ledger_q;
    if (code_q == RESP_OK) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (from_q == IDX_W'(i)) ledger_upd[i*BAL_W +: BAL_W] = ledger_q[i*BAL_W +: BAL_W] - amt_q;
        if (to_q == IDX_W'(i))   ledger_upd[i*BAL_W +: BAL_W] = ledger_q[i*BAL_W +: BAL_W] + amt_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      ledger_q     <= '0;
      datapath_out <= '0;
      from_q       <= '0;
      to_q         <= '0;
      amt_q        <= '0;
      code_q       <= RESP_OK;
      seen_load_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done;
      case (state)
        ST_IDLE: begin
          if (bus.tx_valid && tx_ready_c) begin
            from_q <= bus.tx_from;
            to_q   <= bus.tx_to;
            amt_q  <= bus.tx_amount;
          end
        end
        ST_REQ:  seen_load_q <= 1'b0;
        ST_LOAD: begin
          if (load_registers) begin
            ledger_q    <= mem_q;
            seen_load_q <= 1'b1;
          end
        end
        ST_CHECK: code_q <= check_code;
        ST_UPDATE: begin
          ledger_q     <= ledger_upd;
          datapath_out <= ledger_upd;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    tx_ready_c   = 1'b0;
    load_memory  = 1'b0;
    process      = PROC_IDLE;
    resp_valid_c = 1'b0;
    resp_code_c  = RESP_OK;
    case (state)
      ST_IDLE: begin
        tx_ready_c = finished_init && done;
        if (bus.tx_valid && tx_ready_c) state_nx = ST_REQ;
      end
      ST_REQ: begin
        process     = PROC_REQ;
        load_memory = 1'b1;
        if (!done) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        process = PROC_REQ;
        if (!load_registers && seen_load_q) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        process  = PROC_CHECK;
        state_nx = ST_UPDATE;
      end
      ST_UPDATE: begin
        process  = PROC_UPDATE;
        state_nx = ST_WB;
      end
      ST_WB: begin
        // Edge, not level: done may already be high while memory_control waits for 100.
        process = PROC_WB;
        if (done && !done_q) state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_c = 1'b1;
        resp_code_c  = code_q;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.tx_ready   = tx_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_code  = resp_code_c;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ledger_datapath.sv
// Randomised bench for ledger_datapath with an inline memory_control model and a balance-array reference.
module tb_ledger_datapath;
  import ledger_pkg::*;

  logic              clock;
  logic              resetn;
  logic              finished_init;
  logic              done;
  logic              load_registers;
  logic [DATA_W-1:0] mem_q;
  logic              load_memory;
  logic [2:0]        process;
  logic [DATA_W-1:0] datapath_out;
  state_t            dbg_state;

  ledger_if bus();

  ledger_datapath dut (
    .clock          (clock),
    .resetn         (resetn),
    .finished_init  (finished_init),
    .done           (done),
    .load_registers (load_registers),
    .mem_q          (mem_q),
    .load_memory    (load_memory),
    .process        (process),
    .datapath_out   (datapath_out),
    .dbg_state      (dbg_state),
    .bus            (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int bal[NUM_ACCOUNTS];
  logic [DATA_W-1:0] mem_img;
  logic [DATA_W+1:0] exp_q[$];
  int n_accept = 0;
  int n_resp   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pack_img();
    logic [DATA_W-1:0] img;
    for (int i = 0; i < NUM_ACCOUNTS; i++) img[i*BAL_W +: BAL_W] = bal[i][BAL_W-1:0];
    return img;
  endfunction

  function automatic int img_sum(input logic [DATA_W-1:0] img);
    int s = 0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) s += int'(img[i*BAL_W +: BAL_W]);
    return s;
  endfunction

  // ---------------- driver + memory_control model ----------------
  task automatic do_tx(input int f, input int t, input int a, input bit abort);
    int nb[NUM_ACCOUNTS];
    int code;
    int cnt;
    logic [DATA_W+1:0] exp_entry;
    logic [DATA_W-1:0] wb_img;
    bit stray;

    // reference: the transfer rules evaluated on plain integers
    nb = bal;
    if (f >= NUM_ACCOUNTS || t >= NUM_ACCOUNTS || f == t) code = 1;
    else if (bal[f] < a)                                  code = 2;
    else if (bal[t] + a > 255)                            code = 3;
    else begin
      code = 0;
      nb[f] = bal[f] - a;
      nb[t] = bal[t] + a;
    end
    mem_img = pack_img();
    for (int i = 0; i < NUM_ACCOUNTS; i++) exp_entry[i*BAL_W +: BAL_W] = nb[i][BAL_W-1:0];
    exp_entry[DATA_W +: 2] = code[1:0];

    @(negedge clock);
    bus.tx_valid  = 1'b1;
    bus.tx_from   = f[IDX_W-1:0];
    bus.tx_to     = t[IDX_W-1:0];
    bus.tx_amount = a[BAL_W-1:0];
    cnt = 0;
    while (!bus.tx_ready && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    check("accept", bus.tx_ready, 1);
    @(posedge clock);
    #1 bus.tx_valid = 1'b0;
    if (cnt >= 20) return;
    n_accept++;
    if (!abort) exp_q.push_back(exp_entry);

    cnt = 0;
    while (!load_memory && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("load_req", load_memory, 1);
    @(negedge clock);
    done = 1'b0;
    repeat (2) @(negedge clock);
    load_registers = 1'b1;
    mem_q = mem_img;
    repeat (8) @(negedge clock);
    load_registers = 1'b0;
    mem_q = {$urandom, $urandom};

    cnt = 0;
    while (process != PROC_WB && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("wb_proc", process, PROC_WB);
    check("wb_image", datapath_out, exp_entry[DATA_W-1:0]);

    if (abort) begin
      resetn = 1'b0;
      #1;
      check("rst_proc", process, PROC_IDLE);
      check("rst_dout", datapath_out, 0);
      check("rst_load", load_memory, 0);
      done = 1'b1;
      stray = 1'b0;
      repeat (2) begin
        @(negedge clock);
        stray |= bus.resp_valid;
      end
      resetn = 1'b1;
      repeat (6) begin
        @(negedge clock);
        stray |= bus.resp_valid;
      end
      check("rst_no_resp", stray, 0);
      check("rst_state", dbg_state, ST_IDLE);
      return;
    end

    // requests during write-back must not be taken
    bus.tx_valid  = 1'b1;
    bus.tx_from   = IDX_W'($urandom_range(0, 7));
    bus.tx_to     = IDX_W'($urandom_range(0, 7));
    bus.tx_amount = BAL_W'($urandom);
    wb_img = datapath_out;
    repeat (7) @(negedge clock);
    check("wb_ready", bus.tx_ready, 0);
    check("wb_hold", process, PROC_WB);
    check("wb_stable", datapath_out, wb_img);
    bus.tx_valid = 1'b0;
    mem_img = datapath_out;
    done = 1'b1;

    cnt = 0;
    while (!bus.resp_valid && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("resp_valid", bus.resp_valid, 1);
    if (bus.resp_valid) begin
      n_resp++;
      exp_entry = exp_q.pop_front();
      check("resp_code", bus.resp_code, exp_entry[DATA_W +: 2]);
    end
    @(negedge clock);
    check("resp_pulse", bus.resp_valid, 0);
    bal = nb;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, t, a, sum0;
    resetn = 1'b0;
    finished_init = 1'b0;
    done = 1'b0;
    load_registers = 1'b0;
    mem_q = '0;
    bus.tx_valid = 1'b0;
    bus.tx_from = '0;
    bus.tx_to = '0;
    bus.tx_amount = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) bal[i] = 0;

    // reset in idle
    repeat (3) @(negedge clock);
    check("reset_proc", process, PROC_IDLE);
    check("reset_dout", datapath_out, 0);
    check("reset_load", load_memory, 0);
    check("reset_resp", bus.resp_valid, 0);
    check("reset_code", bus.resp_code, 0);
    check("reset_ready", bus.tx_ready, 0);
    resetn = 1'b1;
    @(negedge clock);
    check("ready_noinit", bus.tx_ready, 0);
    finished_init = 1'b1;
    @(negedge clock);
    check("ready_notdone", bus.tx_ready, 0);
    done = 1'b1;
    @(negedge clock);
    check("ready_up", bus.tx_ready, 1);

    // basic transfer
    bal = '{50, 10, 5, 250, 7, 99};
    do_tx(0, 1, 20, 0);
    check("acct0", bal[0], 30);
    check("acct1_mem", mem_img[1*BAL_W +: BAL_W], 30);
    // insufficient funds, then exact drain
    do_tx(2, 0, 6, 0);
    do_tx(2, 0, 5, 0);
    check("acct2_mem", mem_img[2*BAL_W +: BAL_W], 0);
    // destination overflow, then exact fill
    do_tx(0, 3, 10, 0);
    do_tx(0, 3, 5, 0);
    check("acct3_mem", mem_img[3*BAL_W +: BAL_W], 255);
    // bad indices and zero amount
    do_tx(1, 1, 1, 0);
    do_tx(6, 0, 1, 0);
    do_tx(0, 7, 1, 0);
    do_tx(4, 5, 0, 0);

    // reset during write-back
    do_tx(5, 4, 3, 1);

    // done low in idle blocks acceptance
    done = 1'b0;
    bus.tx_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_notdone", dbg_state, ST_IDLE);
    bus.tx_valid = 1'b0;
    done = 1'b1;

    // back-to-back random transfers, totals conserved
    for (int i = 0; i < NUM_ACCOUNTS; i++) bal[i] = int'($urandom_range(0, 255));
    sum0 = 0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) sum0 += bal[i];
    for (int n = 0; n < 24; n++) begin
      f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 5));
      t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 5));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      do_tx(f, t, a, 0);
    end
    check("conserve", img_sum(mem_img), sum0);
    check("resp_per_accept", n_resp, n_accept - 1);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
